bram_line_reader: RTL

BRAM_LINE_READER -- requirements
Module: bram_line_reader

---
 rtl/bram_line_reader_if.sv | 33 +++
 rtl/bram_line_reader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bram_line_reader_if.sv
// Bundle of the burst-request, BRAM port-B and output-stream signals of bram_line_reader.
// slave  : the reader side (takes the request, drives the BRAM port and the stream).
// master : the requester / memory / sink side that surrounds the reader.
interface bram_line_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    // burst request / status
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    // BRAM port B
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    // output stream
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  start, base_addr, len, bram_dout, m_ready,
        output busy, done, bram_en, bram_addr, m_valid, m_data, m_last
    );

    modport master (
        output start, base_addr, len, bram_dout, m_ready,
        input  busy, done, bram_en, bram_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/bram_line_reader.sv
// Purpose : reads a burst of len words from a BRAM starting at base_addr (address wraps)
//           and streams them out in address order with m_last on the final word.
// Latency : first bram_en one cycle after start; first m_valid RD_LAT+1 cycles after that.
// Backpr. : reads are only issued while in-flight reads plus buffered words fit in
//           FIFO_DEPTH entries, so a stalled sink never loses or duplicates a word.
// Ports   : clk, rst_n (async active-low); bus = bram_line_reader_if.slave
//           (start/base_addr/len/busy/done, bram_en/bram_addr/bram_dout,
//            m_valid/m_ready/m_data/m_last). FIFO_DEPTH must be >= RD_LAT+1.
module bram_line_reader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_line_reader_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [PTR_W-1:0]  PTR_ONE  = 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                bram_en_q, bram_en_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
    logic [ADDR_W:0]     iss_cnt_q, iss_cnt_d;
    logic [ADDR_W:0]     dlv_cnt_q, dlv_cnt_d;
    logic [RD_LAT-1:0]   vld_sr_q, vld_sr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic       accept, pop, arrive, out_free, load_out, fifo_rd, fifo_wr, issue;
    logic [7:0] pend;

    // Shared handshake decode used by both the next-state and the output logic.
    always_comb begin
        accept   = bus.start && (state_q == IDLE);
        pop      = m_valid_q && bus.m_ready;
        arrive   = vld_sr_q[RD_LAT-1];
        out_free = !m_valid_q || pop;
        // Output register is refilled from the FIFO first; bram_dout bypasses an empty FIFO.
        fifo_rd  = out_free && (fifo_cnt_q != '0);
        load_out = out_free && ((fifo_cnt_q != '0) || arrive);
        fifo_wr  = arrive && !(out_free && (fifo_cnt_q == '0));
        // Entries committed after this edge if nothing new is issued: the read on the
        // port now, reads in the latency pipe, and buffered words minus this cycle's pop.
        pend = 8'(bram_en_q) + 8'(fifo_cnt_q) + 8'(m_valid_q) - 8'(pop);
        for (int i = 0; i < RD_LAT; i++) begin
            pend = pend + 8'(vld_sr_q[i]);
        end
        issue = (state_q == READ) && (iss_cnt_q != '0) && (pend < 8'(FIFO_DEPTH));
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state. A len=0 request stays in IDLE and only pulses done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (bus.len != '0)) state_d = READ;
            READ:    if (iss_cnt_q == '0)           state_d = DRAIN;
            DRAIN:   if (pop && m_last_q)           state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // FSM: outputs and datapath next values (all outputs are registered below)
    always_comb begin
        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        nxt_addr_d  = nxt_addr_q;
        iss_cnt_d   = iss_cnt_q;
        dlv_cnt_d   = dlv_cnt_q - {{ADDR_W{1'b0}}, load_out};

        if (accept && (bus.len != '0)) begin
            // The buffer is empty in IDLE, so the first read needs no space check.
            bram_en_d   = 1'b1;
            bram_addr_d = bus.base_addr;
            nxt_addr_d  = bus.base_addr + ADDR_ONE;
            iss_cnt_d   = bus.len - LEN_ONE;
            dlv_cnt_d   = bus.len;
        end else if (issue) begin
            bram_en_d   = 1'b1;
            bram_addr_d = nxt_addr_q;
            nxt_addr_d  = nxt_addr_q + ADDR_ONE;
            iss_cnt_d   = iss_cnt_q - LEN_ONE;
        end

        vld_sr_d[0] = bram_en_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        wr_ptr_d   = fifo_wr ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = fifo_rd ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);

        m_valid_d = m_valid_q && !pop;
        m_last_d  = m_last_q && !pop;
        m_data_d  = m_data_q;
        if (load_out) begin
            m_valid_d = 1'b1;
            m_data_d  = fifo_rd ? mem_q[rd_ptr_q] : bus.bram_dout;
            // Words are loaded in order, so the one loaded with one delivery left is the last.
            m_last_d  = (dlv_cnt_q == LEN_ONE);
        end

        busy_d = (state_d != IDLE);
        done_d = (accept && (bus.len == '0)) || ((state_q == DRAIN) && pop && m_last_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            nxt_addr_q  <= '0;
            iss_cnt_q   <= '0;
            dlv_cnt_q   <= '0;
            vld_sr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            nxt_addr_q  <= nxt_addr_d;
            iss_cnt_q   <= iss_cnt_d;
            dlv_cnt_q   <= dlv_cnt_d;
            vld_sr_q    <= vld_sr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset: only entries covered by fifo_cnt_q are ever read.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= bus.bram_dout;
    end

    assign bus.bram_en   = bram_en_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_last    = m_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
